multicycle_control: RTL and testbench

//  Multi-cycle RISC-V control FSM. Sequences the shared datapath (one ALU, one memory port, one register file)

---
 rtl/multicycle_control_pkg.sv | 44 ++++
 rtl/multicycle_control_if.sv | 48 ++++
 rtl/multicycle_control_mem_wait_timer.sv | 36 +++
 rtl/multicycle_control.sv | 178 +++++++++++++++++
 tb/tb_multicycle_control.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_control_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control_pkg
//  Description : Shared opcodes, FSM state encodings and ALU select encodings
//                for the multi-cycle RISC-V controller.
//  Revision    : 1.0  initial release
// ============================================================================
package multicycle_control_pkg;

    // Opcodes handled by the controller (IR[6:0])
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    // FSM state encodings, also visible on the debug state output
    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC_R = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_BEQ    = 4'd8;
    localparam logic [3:0] S_FAULT  = 4'd9;

    // ALUOp encodings
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALUSrcB encodings
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    // True for every opcode the controller knows how to sequence
    function automatic logic is_legal_op(input logic [6:0] op);
        return (op == OP_R) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ);
    endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_control_if.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control_if
//  Description : Datapath-facing bundle of the multi-cycle controller: status
//                inputs from the datapath/memory and all control strobes.
//  Revision    : 1.0  initial release
// ============================================================================
interface multicycle_control_if;

    logic [6:0] op;
    logic       zero;
    logic       mem_ready;

    logic       PCWrite;
    logic       IRWrite;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       RegWrite;
    logic       MemtoReg;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic       PCSrc;
    logic       Branch;
    logic       instr_done;
    logic       illegal_op;
    logic       fault;
    logic [3:0] state;

    // Controller side: drives the control strobes
    modport master (
        input  op, zero, mem_ready,
        output PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, MemtoReg,
               ALUSrcA, ALUSrcB, ALUOp, PCSrc, Branch, instr_done, illegal_op,
               fault, state
    );

    // Datapath side: consumes the control strobes
    modport slave (
        output op, zero, mem_ready,
        input  PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, MemtoReg,
               ALUSrcA, ALUSrcB, ALUOp, PCSrc, Branch, instr_done, illegal_op,
               fault, state
    );

endinterface
`default_nettype wire

// File: rtl/multicycle_control_mem_wait_timer.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wait_timer
//  Description : Counts memory wait cycles and flags when the next unanswered
//                wait cycle would exceed the allowed limit.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    // Last count value allowed before a further unanswered wait faults
    localparam logic [CNT_W-1:0] c_LIMIT = CNT_W'(MEM_TIMEOUT - 1);

    logic [CNT_W-1:0] r_cnt;

    // Wait counter: cleared on reset/state change, saturating increment
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign expired = (MEM_TIMEOUT != 0) && (r_cnt == c_LIMIT);

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control
//  Description : Multi-cycle RISC-V control FSM (R-format, lw, sw, beq) with
//                memory wait states and a wait-state timeout into FAULT.
//  Revision    : 1.0  initial release
// ============================================================================
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    multicycle_control_if.master   bus
);

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic       w_wait_state;
    logic       w_expired;

    // Only these states hold the memory port open and may stall
    assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEMRD) ||
                          (r_state == S_MEMWR);

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (w_next != r_state),
        .inc     (w_wait_state && !bus.mem_ready),
        .expired (w_expired)
    );

    // Next-state selection; mem_ready takes priority over the timeout
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:  if (bus.mem_ready)  w_next = S_DECODE;
                      else if (w_expired) w_next = S_FAULT;
            S_DECODE: begin
                if ((bus.op == OP_LW) || (bus.op == OP_SW)) w_next = S_MEMADR;
                else if (bus.op == OP_R)                    w_next = S_EXEC_R;
                else if (bus.op == OP_BEQ)                  w_next = S_BEQ;
                else                                        w_next = S_FETCH;
            end
            S_MEMADR: w_next = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (bus.mem_ready)  w_next = S_MEMWB;
                      else if (w_expired) w_next = S_FAULT;
            S_MEMWR:  if (bus.mem_ready)  w_next = S_FETCH;
                      else if (w_expired) w_next = S_FAULT;
            S_EXEC_R: w_next = S_ALUWB;
            S_MEMWB,
            S_ALUWB,
            S_BEQ:    w_next = S_FETCH;
            S_FAULT:  w_next = S_FAULT;
            default:  w_next = S_FETCH;
        endcase
    end

    // State register; reset restarts at FETCH and abandons any instruction
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_FETCH;
        else        r_state <= w_next;
    end

    logic       w_pcwrite, w_irwrite, w_iord, w_memread, w_memwrite;
    logic       w_regwrite, w_memtoreg, w_alusrca, w_pcsrc, w_branch;
    logic       w_done, w_illegal, w_fault;
    logic [1:0] w_alusrcb, w_aluop;

    // Control decode from state; everything is held low during reset
    always_comb begin
        w_pcwrite  = 1'b0;
        w_irwrite  = 1'b0;
        w_iord     = 1'b0;
        w_memread  = 1'b0;
        w_memwrite = 1'b0;
        w_regwrite = 1'b0;
        w_memtoreg = 1'b0;
        w_alusrca  = 1'b0;
        w_alusrcb  = SRCB_REG;
        w_aluop    = ALUOP_ADD;
        w_pcsrc    = 1'b0;
        w_branch   = 1'b0;
        w_done     = 1'b0;
        w_illegal  = 1'b0;
        w_fault    = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_memread = 1'b1;
                w_alusrcb = SRCB_FOUR;
                w_irwrite = bus.mem_ready;
                w_pcwrite = bus.mem_ready;
            end
            S_DECODE: begin
                w_alusrcb = SRCB_IMM;
                w_illegal = !is_legal_op(bus.op);
            end
            S_MEMADR: begin
                w_alusrca = 1'b1;
                w_alusrcb = SRCB_IMM;
            end
            S_MEMRD: begin
                w_iord    = 1'b1;
                w_memread = 1'b1;
            end
            S_MEMWB: begin
                w_regwrite = 1'b1;
                w_memtoreg = 1'b1;
                w_done     = 1'b1;
            end
            S_MEMWR: begin
                w_iord     = 1'b1;
                w_memwrite = 1'b1;
                w_done     = bus.mem_ready;
            end
            S_EXEC_R: begin
                w_alusrca = 1'b1;
                w_aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                w_regwrite = 1'b1;
                w_done     = 1'b1;
            end
            S_BEQ: begin
                w_alusrca = 1'b1;
                w_aluop   = ALUOP_SUB;
                w_branch  = 1'b1;
                w_pcsrc   = 1'b1;
                w_pcwrite = bus.zero;
                w_done    = 1'b1;
            end
            S_FAULT:  w_fault = 1'b1;
            default:  ;
        endcase
        if (!rst_n) begin
            w_pcwrite  = 1'b0;
            w_irwrite  = 1'b0;
            w_iord     = 1'b0;
            w_memread  = 1'b0;
            w_memwrite = 1'b0;
            w_regwrite = 1'b0;
            w_memtoreg = 1'b0;
            w_alusrca  = 1'b0;
            w_alusrcb  = 2'b00;
            w_aluop    = 2'b00;
            w_pcsrc    = 1'b0;
            w_branch   = 1'b0;
            w_done     = 1'b0;
            w_illegal  = 1'b0;
            w_fault    = 1'b0;
        end
    end

    assign bus.PCWrite    = w_pcwrite;
    assign bus.IRWrite    = w_irwrite;
    assign bus.IorD       = w_iord;
    assign bus.MemRead    = w_memread;
    assign bus.MemWrite   = w_memwrite;
    assign bus.RegWrite   = w_regwrite;
    assign bus.MemtoReg   = w_memtoreg;
    assign bus.ALUSrcA    = w_alusrca;
    assign bus.ALUSrcB    = w_alusrcb;
    assign bus.ALUOp      = w_aluop;
    assign bus.PCSrc      = w_pcsrc;
    assign bus.Branch     = w_branch;
    assign bus.instr_done = w_done;
    assign bus.illegal_op = w_illegal;
    assign bus.fault      = w_fault;
    assign bus.state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_control
//  Description : Self-checking bench for multicycle_control: directed
//                scenarios followed by randomized instruction streams.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_multicycle_control;
    import multicycle_control_pkg::*;

    localparam int TO = 4;

    typedef logic [20:0] vec_t;

    // Output-vector field positions
    localparam vec_t PCW   = 21'd1 << 20;
    localparam vec_t IRW   = 21'd1 << 19;
    localparam vec_t IORD  = 21'd1 << 18;
    localparam vec_t MRD   = 21'd1 << 17;
    localparam vec_t MWR   = 21'd1 << 16;
    localparam vec_t RW    = 21'd1 << 15;
    localparam vec_t M2R   = 21'd1 << 14;
    localparam vec_t SRCA  = 21'd1 << 13;
    localparam vec_t PCSRC = 21'd1 << 8;
    localparam vec_t BR    = 21'd1 << 7;
    localparam vec_t DONE  = 21'd1 << 6;
    localparam vec_t ILL   = 21'd1 << 5;
    localparam vec_t FLT   = 21'd1 << 4;

    function automatic vec_t SB(input logic [1:0] v); return vec_t'(v) << 11; endfunction
    function automatic vec_t AO(input logic [1:0] v); return vec_t'(v) << 9;  endfunction
    function automatic vec_t ST(input logic [3:0] s); return vec_t'(s);       endfunction

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    multicycle_control_if bus();

    multicycle_control #(
        .MEM_TIMEOUT (TO),
        .CNT_W       (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    vec_t w_obs;
    assign w_obs = {bus.PCWrite, bus.IRWrite, bus.IorD, bus.MemRead, bus.MemWrite,
                    bus.RegWrite, bus.MemtoReg, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp,
                    bus.PCSrc, bus.Branch, bus.instr_done, bus.illegal_op, bus.fault,
                    bus.state};

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // One clock cycle: compare at the falling edge, then advance past the rising edge
    task automatic chk(input string tag, input vec_t e);
        @(negedge clk);
        cyc++;
        checks++;
        assert (w_obs === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, w_obs, e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic lat_chk(input string tag, input int expected);
        checks++;
        assert (cyc === expected) else begin
            errors++;
            $error("FAIL %s latency observed=%0d expected=%0d", tag, cyc, expected);
        end
    endtask

    // A memory-wait phase: nwait unanswered cycles then a ready cycle,
    // unless TO unanswered cycles pass first, in which case the FSM faults.
    task automatic wait_phase(input string tag, input vec_t e_wait, input vec_t e_ready,
                              input int nwait, output bit faulted);
        faulted = 1'b0;
        for (int i = 0; i <= nwait; i++) begin
            if (i == TO) begin
                faulted = 1'b1;
                return;
            end
            bus.mem_ready = (i == nwait);
            bus.zero      = 1'($urandom);
            chk(tag, (i == nwait) ? e_ready : e_wait);
        end
    endtask

    // Reset held for two cycles: outputs all low, state reaches FETCH after the first edge
    task automatic do_reset(input logic [3:0] cur);
        rst_n         = 1'b0;
        bus.mem_ready = 1'b1;
        bus.zero      = 1'($urandom);
        chk("reset_first", ST(cur));
        bus.mem_ready = 1'($urandom);
        chk("reset_hold", ST(S_FETCH));
        rst_n = 1'b1;
    endtask

    task automatic fault_tail();
        for (int i = 0; i < 3; i++) begin
            bus.mem_ready = 1'($urandom);
            bus.zero      = 1'($urandom);
            chk("fault_sticky", FLT | ST(S_FAULT));
        end
        do_reset(S_FAULT);
    endtask

    // Runs one instruction; zsel 0/1 forces zero in BEQ, 2 randomizes it
    task automatic run_instr(input logic [6:0] opc, input int fw, input int mw, input int zsel);
        vec_t e_f;
        vec_t e;
        bit   flt;
        logic z;
        e_f = ST(S_FETCH) | MRD | SB(SRCB_FOUR);
        cyc = 0;
        bus.op = 7'($urandom);
        wait_phase("fetch", e_f, e_f | IRW | PCW, fw, flt);
        if (flt) begin fault_tail(); return; end

        bus.op        = opc;
        bus.mem_ready = 1'($urandom);
        bus.zero      = 1'($urandom);
        if (!((opc == OP_R) || (opc == OP_LW) || (opc == OP_SW) || (opc == OP_BEQ))) begin
            chk("decode_illegal", ST(S_DECODE) | SB(SRCB_IMM) | ILL);
            return;
        end
        chk("decode", ST(S_DECODE) | SB(SRCB_IMM));

        if (opc == OP_LW || opc == OP_SW) begin
            bus.mem_ready = 1'($urandom);
            chk("memadr", ST(S_MEMADR) | SRCA | SB(SRCB_IMM));
            if (opc == OP_LW) begin
                e = ST(S_MEMRD) | IORD | MRD;
                wait_phase("memrd", e, e, mw, flt);
                if (flt) begin fault_tail(); return; end
                bus.mem_ready = 1'($urandom);
                chk("memwb", ST(S_MEMWB) | RW | M2R | DONE);
                lat_chk("lw", 5 + fw + mw);
            end else begin
                e = ST(S_MEMWR) | IORD | MWR;
                wait_phase("memwr", e, e | DONE, mw, flt);
                if (flt) begin fault_tail(); return; end
                lat_chk("sw", 4 + fw + mw);
            end
        end else if (opc == OP_R) begin
            bus.mem_ready = 1'($urandom);
            chk("exec_r", ST(S_EXEC_R) | SRCA | SB(SRCB_REG) | AO(ALUOP_FUNCT));
            bus.mem_ready = 1'($urandom);
            chk("aluwb", ST(S_ALUWB) | RW | DONE);
            lat_chk("r", 4 + fw);
        end else begin
            z = (zsel == 2) ? 1'($urandom) : 1'(zsel);
            bus.zero      = z;
            bus.mem_ready = 1'($urandom);
            chk("beq", ST(S_BEQ) | SRCA | AO(ALUOP_SUB) | BR | PCSRC | DONE | (z ? PCW : '0));
            lat_chk("beq", 3 + fw);
        end
    endtask

    function automatic logic [6:0] pick_op(input int k);
        logic [6:0] o;
        case (k)
            0: o = OP_R;
            1: o = OP_LW;
            2: o = OP_SW;
            3: o = OP_BEQ;
            default: begin
                o = 7'($urandom);
                if (o == OP_R || o == OP_LW || o == OP_SW || o == OP_BEQ) o = 7'b0010011;
            end
        endcase
        return o;
    endfunction

    function automatic int pick_wait();
        return ($urandom_range(0, 9) == 0) ? int'($urandom_range(TO, TO + 1))
                                           : int'($urandom_range(0, 3));
    endfunction

    initial begin
        rst_n         = 1'b0;
        bus.op        = 7'd0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_state", ST(S_FETCH));
        chk("reset_state_hold", ST(S_FETCH));
        rst_n = 1'b1;

        run_instr(OP_R,   0, 0, 2);
        run_instr(OP_LW,  0, 2, 2);
        run_instr(OP_BEQ, 0, 0, 1);
        run_instr(OP_BEQ, 0, 0, 0);
        run_instr(7'b0010011, 0, 0, 2);
        run_instr(OP_SW,  0, TO, 2);
        run_instr(OP_SW,  0, TO - 1, 2);
        run_instr(OP_R,   TO, 0, 2);

        // Reset in the middle of a stalled store
        cyc = 0;
        bus.mem_ready = 1'b1;
        chk("abort_fetch", ST(S_FETCH) | MRD | SB(SRCB_FOUR) | IRW | PCW);
        bus.op = OP_SW;
        chk("abort_decode", ST(S_DECODE) | SB(SRCB_IMM));
        chk("abort_memadr", ST(S_MEMADR) | SRCA | SB(SRCB_IMM));
        bus.mem_ready = 1'b0;
        chk("abort_memwr0", ST(S_MEMWR) | IORD | MWR);
        chk("abort_memwr1", ST(S_MEMWR) | IORD | MWR);
        do_reset(S_MEMWR);
        run_instr(OP_SW, TO - 1, TO - 1, 2);

        // Randomized instruction stream with occasional resets
        for (int n = 0; n < 60; n++) begin
            run_instr(pick_op($urandom_range(0, 4)), pick_wait(), pick_wait(), 2);
            if ($urandom_range(0, 19) == 0) do_reset(S_FETCH);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
